// File: rtl/layer_out_gather.sv
`timescale 1ns/1ps
// Gathers one word per enabled input channel into a frame buffer, then replays
// the frame as a serial AXI-stream tagged with channel index and last-word flag.
module layer_out_gather #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 16,
  parameter int CH_W   = $clog2(N_CH),
  parameter int CNT_W  = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [N_CH*DATA_W-1:0] in_TDATA,
  input  logic [N_CH-1:0]        in_TVALID,
  output logic [N_CH-1:0]        in_TREADY,
  input  logic [N_CH-1:0]        ch_en,
  output logic [DATA_W-1:0]      out_TDATA,
  output logic [CH_W-1:0]        out_TUSER,
  output logic                   out_TLAST,
  output logic                   out_TVALID,
  input  logic                   out_TREADY,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   busy
);

  typedef enum logic {GATHER = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [N_CH];
  logic [N_CH-1:0]   captured_q, en_q, en_eff, cap, cap_all;
  logic [CH_W-1:0]   rd_idx_q, first_idx, next_idx, last_idx;
  logic [CNT_W-1:0]  frame_count_q;
  logic              frame_done, out_hs;

  // Handshakes: a word moves on a rising edge where VALID and READY are both
  // high; VALID never waits on READY, and a stalled output holds its payload.

  // The mask tracks ch_en until the first capture, then stays frozen for the frame.
  assign en_eff     = (captured_q == '0) ? ch_en : en_q;
  assign in_TREADY  = (state_q == GATHER) ? (en_eff & ~captured_q) : '0;
  assign cap        = in_TVALID & in_TREADY;
  assign cap_all    = captured_q | cap;
  assign frame_done = (state_q == GATHER) && (cap_all == en_eff) && (en_eff != '0);

  always_comb begin
    first_idx = '0;
    last_idx  = '0;
    next_idx  = rd_idx_q;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (en_eff[k]) first_idx = CH_W'(k);
      if (en_q[k] && (k > int'(rd_idx_q))) next_idx = CH_W'(k);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (en_q[k]) last_idx = CH_W'(k);
    end
  end

  // Output side is driven from registers only.
  assign out_TVALID  = (state_q == DRAIN);
  assign out_TDATA   = out_TVALID ? buf_q[rd_idx_q] : '0;
  assign out_TUSER   = out_TVALID ? rd_idx_q : '0;
  assign out_TLAST   = out_TVALID && (rd_idx_q == last_idx);
  assign out_hs      = out_TVALID && out_TREADY;
  assign busy        = out_TVALID || (captured_q != '0);
  assign frame_count = frame_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      GATHER:  if (frame_done) state_d = DRAIN;
      DRAIN:   if (out_hs && out_TLAST) state_d = GATHER;
      default: state_d = GATHER;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= GATHER;
      captured_q    <= '0;
      en_q          <= '0;
      rd_idx_q      <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == GATHER) begin
        if (captured_q == '0) en_q <= ch_en;
        captured_q <= cap_all;
        if (frame_done) rd_idx_q <= first_idx;
      end else if (out_hs) begin
        if (out_TLAST) begin
          captured_q    <= '0;
          frame_count_q <= frame_count_q + CNT_W'(1);
        end else begin
          rd_idx_q <= next_idx;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int k = 0; k < N_CH; k++) buf_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cap[k]) buf_q[k] <= in_TDATA[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_layer_out_gather.sv
`timescale 1ns/1ps
// Bench for layer_out_gather: per-scenario tasks compare the serial stream
// against a frame model built from the enable mask and the captured words.
module tb_layer_out_gather;

  localparam int DATA_W = 16;
  localparam int N_CH   = 16;
  localparam int CH_W   = 4;
  localparam int CNT_W  = 8;
  localparam int W      = 1 + CH_W + DATA_W;

  logic                   ap_clk, ap_rst;
  logic [N_CH*DATA_W-1:0] in_TDATA;
  logic [N_CH-1:0]        in_TVALID, in_TREADY, ch_en;
  logic [DATA_W-1:0]      out_TDATA;
  logic [CH_W-1:0]        out_TUSER;
  logic                   out_TLAST, out_TVALID, out_TREADY;
  logic [CNT_W-1:0]       frame_count;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0]  exp_fc;
  logic [DATA_W-1:0] frame_data [N_CH];
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      obs_q[$];

  layer_out_gather #(.DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
    .ch_en(ch_en),
    .out_TDATA(out_TDATA), .out_TUSER(out_TUSER), .out_TLAST(out_TLAST),
    .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
    .frame_count(frame_count), .busy(busy)
  );

  // clock / watchdog
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference model: one word per enabled channel in ascending order, last flag on the final one.
  task automatic load_frame(input logic [N_CH-1:0] mask, input bit seq_data);
    logic [W-1:0] w;
    exp_q.delete();
    for (int k = 0; k < N_CH; k++) begin
      frame_data[k] = seq_data ? DATA_W'(16'h100 + k) : DATA_W'($urandom);
      in_TDATA[k*DATA_W +: DATA_W] = frame_data[k];
      if (mask[k]) exp_q.push_back({1'b0, CH_W'(k), frame_data[k]});
    end
    if (exp_q.size() > 0) begin
      w = exp_q.pop_back();
      w[W-1] = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  // Records output handshakes; bp_mode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  task automatic collect(input int budget, input int max_words, input int bp_mode,
                         output int cycles, output int stable_err, output int rdy_err);
    logic [W-1:0] snap, prev_snap;
    logic v, prev_stall;
    int words;
    cycles = 0; stable_err = 0; rdy_err = 0; words = 0;
    prev_stall = 1'b0; prev_snap = '0;
    obs_q.delete();
    while (cycles < budget) begin
      case (bp_mode)
        0:       out_TREADY = 1'b1;
        1:       out_TREADY = ((cycles % 4) == 0) || ((cycles % 4) == 3);
        default: out_TREADY = 1'($urandom_range(0, 1));
      endcase
      #1;
      v    = out_TVALID;
      snap = {out_TLAST, out_TUSER, out_TDATA};
      if (v && (in_TREADY != '0)) rdy_err++;
      if (prev_stall && (!v || (snap !== prev_snap))) stable_err++;
      prev_stall = v && !out_TREADY;
      prev_snap  = snap;
      tick();
      cycles++;
      if (v && out_TREADY) begin
        obs_q.push_back(snap);
        words++;
        if (snap[W-1] || (words == max_words)) break;
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    ap_rst = 1'b1; in_TVALID = '0; out_TREADY = 1'b0; in_TDATA = '0;
    ch_en = N_CH'($urandom);
    exp_fc = '0;
    #2;
    n_checks++; if (in_TREADY !== ch_en) begin n_fail++; $display("FAIL rst_in_ready: got %h expected %h", in_TREADY, ch_en); end
    n_checks++; if ({out_TVALID, out_TLAST, out_TUSER, out_TDATA} !== '0) begin n_fail++; $display("FAIL rst_out: got v=%b l=%b u=%h d=%h expected all 0", out_TVALID, out_TLAST, out_TUSER, out_TDATA); end
    n_checks++; if (frame_count !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_count_busy: got fc=%0d busy=%b expected 0/0", frame_count, busy); end
    tick(); tick();
    ap_rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int cyc, se, re;
    ch_en = '1; out_TREADY = 1'b1;
    load_frame('1, 1'b1);
    in_TVALID = '1;
    #1;
    n_checks++; if (out_TVALID !== 1'b0) begin n_fail++; $display("FAIL full_pre_valid: got %b expected 0", out_TVALID); end
    tick();
    n_checks++; if (out_TVALID !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL full_latency: got valid=%b busy=%b expected 1/1", out_TVALID, busy); end
    in_TVALID = '0;
    collect(40, N_CH, 0, cyc, se, re);
    exp_fc++;
    n_checks++; if (cyc != N_CH) begin n_fail++; $display("FAIL full_drain_cycles: got %0d expected %0d", cyc, N_CH); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_words: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
    end
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", frame_count, exp_fc); end
    n_checks++; if (in_TREADY !== ch_en) begin n_fail++; $display("FAIL full_reready: got %h expected %h", in_TREADY, ch_en); end
  endtask

  task automatic test_staggered();
    int cyc, se, re;
    logic [N_CH-1:0] exp_rdy;
    ch_en = '1; out_TREADY = 1'b1;
    load_frame('1, 1'b0);
    for (int c = 0; c <= 3 * (N_CH - 1); c++) begin
      for (int k = 0; k < N_CH; k++) begin
        in_TVALID[k] = (c >= 3 * k);
        exp_rdy[k]   = (c <= 3 * k);
      end
      #1;
      n_checks++; if (in_TREADY !== exp_rdy) begin n_fail++; $display("FAIL stag_ready c%0d: got %h expected %h", c, in_TREADY, exp_rdy); end
      n_checks++; if (out_TVALID !== 1'b0) begin n_fail++; $display("FAIL stag_early_out c%0d: got %b expected 0", c, out_TVALID); end
      tick();
    end
    in_TVALID = '0;
    collect(40, N_CH, 0, cyc, se, re);
    exp_fc++;
    n_checks++; if (cyc != N_CH) begin n_fail++; $display("FAIL stag_drain_cycles: got %0d expected %0d", cyc, N_CH); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stag_words: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stag_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
    end
  endtask

  task automatic test_mask();
    int cyc, se, re;
    out_TREADY = 1'b1;
    ch_en = 16'h8005;
    load_frame(16'h8005, 1'b0);
    in_TVALID = 16'h0001;
    #1;
    n_checks++; if (in_TREADY !== 16'h8005) begin n_fail++; $display("FAIL mask_ready0: got %h expected 8005", in_TREADY); end
    tick();
    ch_en = 16'hFFFF;
    in_TVALID = 16'hFFFF;
    #1;
    n_checks++; if (in_TREADY !== 16'h8004) begin n_fail++; $display("FAIL mask_frozen_ready: got %h expected 8004", in_TREADY); end
    n_checks++; if (out_TVALID !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mask_partial: got valid=%b busy=%b expected 0/1", out_TVALID, busy); end
    tick();
    in_TVALID = '0;
    collect(20, N_CH, 0, cyc, se, re);
    exp_fc++;
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL mask_drain_cycles: got %0d expected 3", cyc); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mask_words: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mask_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
    end
    n_checks++; if (in_TREADY !== 16'hFFFF || frame_count !== exp_fc) begin n_fail++; $display("FAIL mask_after: got rdy=%h fc=%0d expected FFFF/%0d", in_TREADY, frame_count, exp_fc); end
  endtask

  task automatic test_backpressure();
    int cyc, se, re;
    logic [N_CH-1:0] m;
    for (int f = 0; f < 3; f++) begin
      m = (f == 0) ? '1 : N_CH'($urandom_range(1, (1 << N_CH) - 1));
      ch_en = m;
      load_frame(m, 1'b0);
      in_TVALID = '1;
      collect(100, N_CH, 1, cyc, se, re);
      in_TVALID = '0;
      exp_fc++;
      n_checks++; if (se != 0) begin n_fail++; $display("FAIL bp_stable f%0d: got %0d unstable stalls expected 0", f, se); end
      n_checks++; if (re != 0) begin n_fail++; $display("FAIL bp_in_ready f%0d: got %0d drain cycles with in_TREADY expected 0", f, re); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_words f%0d: got %0d expected %0d", f, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word f%0d w%0d: got %h expected %h", f, i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
      end
      n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL bp_count f%0d: got %0d expected %0d", f, frame_count, exp_fc); end
    end
  endtask

  task automatic test_zero_mask();
    ch_en = '0; out_TREADY = 1'b1;
    for (int c = 0; c < 50; c++) begin
      in_TVALID = N_CH'($urandom);
      in_TDATA  = {N_CH{16'($urandom)}};
      #1;
      n_checks++; if (in_TREADY !== '0 || out_TVALID !== 1'b0) begin n_fail++; $display("FAIL zero_idle c%0d: got rdy=%h valid=%b expected 0/0", c, in_TREADY, out_TVALID); end
      tick();
    end
    in_TVALID = '0;
    n_checks++; if (frame_count !== exp_fc || busy !== 1'b0) begin n_fail++; $display("FAIL zero_count: got fc=%0d busy=%b expected %0d/0", frame_count, busy, exp_fc); end
  endtask

  task automatic test_reset_mid_drain();
    int cyc, se, re;
    ch_en = '1;
    load_frame('1, 1'b0);
    in_TVALID = '1;
    collect(40, 5, 0, cyc, se, re);
    in_TVALID = '0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmd_pre_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
    end
    ap_rst = 1'b1;
    exp_fc = '0;
    #1;
    n_checks++; if ({out_TVALID, out_TLAST, out_TUSER, out_TDATA} !== '0) begin n_fail++; $display("FAIL rmd_out: got v=%b l=%b u=%h d=%h expected all 0", out_TVALID, out_TLAST, out_TUSER, out_TDATA); end
    n_checks++; if (frame_count !== exp_fc || busy !== 1'b0) begin n_fail++; $display("FAIL rmd_count: got fc=%0d busy=%b expected 0/0", frame_count, busy); end
    tick(); tick();
    ap_rst = 1'b0;
    load_frame('1, 1'b0);
    in_TVALID = '1;
    collect(40, N_CH, 0, cyc, se, re);
    in_TVALID = '0;
    exp_fc++;
    n_checks++; if (cyc != N_CH + 1) begin n_fail++; $display("FAIL rmd_cycles: got %0d expected %0d", cyc, N_CH + 1); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmd_words: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmd_word%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
    end
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL rmd_count_after: got %0d expected %0d", frame_count, exp_fc); end
  endtask

  task automatic test_back_to_back();
    int cyc, se, re;
    logic [N_CH-1:0] m;
    in_TVALID = '1;
    for (int f = 0; f < 5; f++) begin
      m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      ch_en = m;
      load_frame(m, 1'b0);
      collect(40, N_CH, 2 * (f % 2), cyc, se, re);
      exp_fc++;
      if (f % 2 == 0) begin
        n_checks++; if (cyc != $countones(m) + 1) begin n_fail++; $display("FAIL b2b_period f%0d: got %0d expected %0d", f, cyc, $countones(m) + 1); end
      end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_words f%0d: got %0d expected %0d", f, obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word f%0d w%0d: got %h expected %h", f, i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]); end
      end
      n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL b2b_count f%0d: got %0d expected %0d", f, frame_count, exp_fc); end
    end
    in_TVALID = '0;
  endtask

  task automatic test_wrap();
    int frames;
    int budget;
    bit seen_max;
    ap_rst = 1'b1; #1; tick(); ap_rst = 1'b0;
    exp_fc = '0;
    ch_en = N_CH'(1); out_TREADY = 1'b1; in_TVALID = N_CH'(1);
    in_TDATA = {N_CH{16'($urandom)}};
    frames = 0; budget = 0; seen_max = 1'b0;
    while (frames < (1 << CNT_W) && budget < 4 * (1 << CNT_W)) begin
      #1;
      if (out_TVALID && out_TLAST) frames++;
      tick();
      budget++;
      if (frames == (1 << CNT_W) - 1 && !seen_max) begin
        seen_max = 1'b1;
        n_checks++; if (frame_count !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL wrap_max: got %0d expected %0d", frame_count, (1 << CNT_W) - 1); end
      end
    end
    in_TVALID = '0;
    n_checks++; if (frames != (1 << CNT_W)) begin n_fail++; $display("FAIL wrap_frames: got %0d expected %0d", frames, 1 << CNT_W); end
    n_checks++; if (frame_count !== '0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_staggered();
    test_mask();
    test_backpressure();
    test_zero_mask();
    test_reset_mid_drain();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_out_gather.md
# layer_out_gather

Collects one word from each of `N_CH` parallel AXI-stream output channels of an inference core (the `layerN_out_V_data_k_V` ports) into a frame buffer. It then replays that frame as a single serial AXI-stream with channel index and last-word marking. It sits between the network core and a single-port sink such as a DMA or UART bridge. A runtime channel-enable mask lets the same instance serve layers with fewer active outputs.

## Interface
Parameters:
- `DATA_W`, 16, width of each channel word (fixed-point activation)
- `N_CH`, 16, number of input channels, at least 2
- `CH_W`, $clog2(N_CH), width of channel index
- `CNT_W`, 16, width of frame counter

Ports:
- `ap_clk` in 1: single clock, all logic on rising edge
- `ap_rst` in 1: asynchronous, active-high reset
- `in_TDATA` in N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W]
- `in_TVALID` in N_CH: per-channel valid
- `in_TREADY` out N_CH: per-channel ready
- `ch_en` in N_CH: channel-enable mask, bit k enables channel k
- `out_TDATA` out DATA_W: serial data
- `out_TUSER` out CH_W: channel index of the current `out_TDATA`
- `out_TLAST` out 1: high on the last word of the frame
- `out_TVALID` out 1: output valid
- `out_TREADY` in 1: downstream ready
- `frame_count` out CNT_W: number of frames fully emitted, wraps
- `busy` out 1: high when a frame is partially captured or draining

## Operation
- Two states:
  - GATHER (reset state)
  - DRAIN
- Registers:
  - `buf[N_CH]` of DATA_W
  - `captured[N_CH]`
  - `en_q[N_CH]`
  - `rd_idx[CH_W]`
  - `frame_count`
- Effective mask `en_eff`: equals `ch_en` while `captured == 0`, otherwise `en_q`.
- `en_q` loads `ch_en` on every GATHER cycle with `captured == 0`. Once the first word of a frame is captured, the mask is frozen for that frame.
- GATHER:
  - `in_TREADY[k] = en_eff[k] & ~captured[k]`.
  - On `in_TVALID[k] & in_TREADY[k]`: `buf[k] <= data_k`, `captured[k] <= 1`.
  - Any number of channels may capture in the same cycle.
  - Frame is complete when `(captured | this-cycle captures) == en_eff` and `en_eff != 0`.
  - On completion: next state is DRAIN, and `rd_idx` loads the lowest enabled index.
  - If `en_eff == 0`: stay in GATHER, no output, count unchanged.
- DRAIN:
  - `in_TREADY = 0` on all channels.
  - `out_TVALID = 1`, `out_TDATA = buf[rd_idx]`, `out_TUSER = rd_idx`.
  - `out_TLAST = 1` when `rd_idx` is the highest set bit of `en_q`.
  - On handshake with `out_TLAST = 0`: `rd_idx` advances to the next higher set bit of `en_q` (priority search). Disabled channels are skipped with no bubble.
  - On handshake with `out_TLAST = 1`: `captured <= 0`, `frame_count <= frame_count + 1` (modulo 2^CNT_W, so all-ones wraps to 0), next state is GATHER.
- `busy` = (state == DRAIN) | (`captured != 0`).
- Output data, index and last are muxed from registers only. There is no combinational path from `in_*` to `out_*`.
- Changes to `ch_en` mid-frame (after the first capture) are ignored until the next frame.

## Timing
- Reset values (asynchronous assert; state DRAIN->GATHER on assert):
  - `in_TREADY`: equals `ch_en`
  - `out_TVALID = 0`, `out_TDATA = 0`, `out_TUSER = 0`, `out_TLAST = 0`
  - `frame_count = 0`, `busy = 0`
  - `captured = 0`, `buf = 0`
- Reset asserted mid-frame or mid-drain aborts the frame. Captured data is discarded and not counted.
- Latency: last required capture at edge t, first `out_TVALID` visible after edge t.
- With `out_TREADY` held high, M enabled channels drain in M cycles.
- After the TLAST handshake at edge t, `in_TREADY` is re-asserted after edge t.
- Minimum frame period with all inputs valid and sink ready: M+1 cycles.
- `out_TVALID`, `out_TDATA`, `out_TUSER` and `out_TLAST` hold stable while `out_TREADY = 0` (AXI-stream rule).
- `in_TVALID` may drop before capture. A channel already captured ignores further valid until the next frame.

## Test plan
- Full frame, N_CH=16, all enabled, all inputs valid with data k+0x100, sink ready:
  - 16 outputs 0x100..0x10F with TUSER 0..15 and TLAST only on 15.
  - `frame_count` 0->1.
  - First `out_TVALID` one cycle after capture.
- Staggered arrival: channel k asserts valid at cycle 3k.
  - No output until channel 15 is captured.
  - Each `in_TREADY[k]` drops the cycle after its own capture.
- Mask `ch_en = 0x8005`:
  - Outputs for channels 0, 2 and 15 only, back-to-back, TLAST on 15.
  - Changing `ch_en` to 0xFFFF after the first capture has no effect on that frame.
- Backpressure: `out_TREADY` toggles 1,0,0,1 repeatedly.
  - Outputs remain stable while stalled; no word lost or duplicated.
  - All `in_TREADY` stay 0 throughout the drain.
- `ch_en = 0`: no `in_TREADY`, no output, `frame_count` unchanged for 50 cycles.
- Reset mid-drain after word 5:
  - Outputs return to 0 immediately and `frame_count` keeps its reset value 0.
  - The next full frame is emitted intact starting at TUSER 0.
- Wrap: preload by running 65,536 frames; `frame_count` reads 0 afterwards.
